// File: rtl/ysyx_220066_lsu.sv
// Load/store unit: one outstanding core access, issued as a single 8-byte-aligned
// bus beat with byte mask; load data is lane-extracted and sign/zero-extended.
module ysyx_220066_lsu #(
    parameter int unsigned TIMEOUT = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [63:0] req_addr,
    input  logic [2:0]  req_memop,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    output logic [63:0] resp_rdata,
    output logic        resp_err,
    output logic        bus_req_valid,
    input  logic        bus_req_ready,
    output logic        bus_req_wr,
    output logic [63:0] bus_req_addr,
    output logic [7:0]  bus_req_wmask,
    output logic [63:0] bus_req_wdata,
    input  logic        bus_resp_valid,
    input  logic [63:0] bus_resp_rdata,
    input  logic        bus_resp_err
);
    localparam int unsigned CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          ld_wr;
    logic [2:0]    ld_memop;
    logic [2:0]    ld_off;

    logic          req_misaligned;
    logic          req_err;
    logic [7:0]    st_mask;
    logic [63:0]   st_data;
    logic [63:0]   ld_shift;
    logic [63:0]   ld_ext;

    assign req_ready = (state == S_IDLE);

    // Size comes from memop[1:0] for both loads and stores.
    always_comb begin
        case (req_memop[1:0])
            2'd0:    req_misaligned = 1'b0;
            2'd1:    req_misaligned = req_addr[0];
            2'd2:    req_misaligned = |req_addr[1:0];
            default: req_misaligned = |req_addr[2:0];
        endcase
        req_err = req_misaligned || (req_memop == 3'b111);
        case (req_memop[1:0])
            2'd0:    st_mask = 8'h01 << req_addr[2:0];
            2'd1:    st_mask = 8'h03 << req_addr[2:0];
            2'd2:    st_mask = 8'h0f << req_addr[2:0];
            default: st_mask = 8'hff;
        endcase
        st_data = req_wdata << {req_addr[2:0], 3'b000};
    end

    always_comb begin
        ld_shift = bus_resp_rdata >> {ld_off, 3'b000};
        case (ld_memop)
            3'b000:  ld_ext = {{56{ld_shift[7]}}, ld_shift[7:0]};
            3'b001:  ld_ext = {{48{ld_shift[15]}}, ld_shift[15:0]};
            3'b010:  ld_ext = {{32{ld_shift[31]}}, ld_shift[31:0]};
            3'b100:  ld_ext = {56'd0, ld_shift[7:0]};
            3'b101:  ld_ext = {48'd0, ld_shift[15:0]};
            3'b110:  ld_ext = {32'd0, ld_shift[31:0]};
            default: ld_ext = ld_shift;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            cnt           <= '0;
            ld_wr         <= 1'b0;
            ld_memop      <= '0;
            ld_off        <= '0;
            resp_valid    <= 1'b0;
            resp_rdata    <= '0;
            resp_err      <= 1'b0;
            bus_req_valid <= 1'b0;
            bus_req_wr    <= 1'b0;
            bus_req_addr  <= '0;
            bus_req_wmask <= '0;
            bus_req_wdata <= '0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        ld_wr    <= req_wr;
                        ld_memop <= req_memop;
                        ld_off   <= req_addr[2:0];
                        if (req_err) begin
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                            state      <= S_RESP;
                        end else begin
                            bus_req_valid <= 1'b1;
                            bus_req_wr    <= req_wr;
                            bus_req_addr  <= {req_addr[63:3], 3'b000};
                            bus_req_wmask <= req_wr ? st_mask : 8'h00;
                            bus_req_wdata <= req_wr ? st_data : 64'd0;
                            state         <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (bus_req_ready) begin
                        bus_req_valid <= 1'b0;
                        cnt           <= '0;
                        state         <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus_resp_valid) begin
                        resp_valid <= 1'b1;
                        resp_err   <= bus_resp_err;
                        resp_rdata <= (bus_resp_err || ld_wr) ? 64'd0 : ld_ext;
                        cnt        <= '0;
                        state      <= S_RESP;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                        resp_rdata <= '0;
                        cnt        <= '0;
                        state      <= S_RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ysyx_220066_lsu.sv
// Self-checking bench for ysyx_220066_lsu: directed scenarios plus randomized
// accesses checked against an arithmetic reference of the load/store rules.
module tb_ysyx_220066_lsu;
    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_wr;
    logic [63:0] req_addr, req_wdata;
    logic [2:0]  req_memop;
    logic        resp_valid, resp_err;
    logic [63:0] resp_rdata;
    logic        bus_req_valid, bus_req_ready, bus_req_wr;
    logic [63:0] bus_req_addr, bus_req_wdata;
    logic [7:0]  bus_req_wmask;
    logic        bus_resp_valid, bus_resp_err;
    logic [63:0] bus_resp_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    ysyx_220066_lsu #(.TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_memop(req_memop), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready),
        .bus_req_wr(bus_req_wr), .bus_req_addr(bus_req_addr),
        .bus_req_wmask(bus_req_wmask), .bus_req_wdata(bus_req_wdata),
        .bus_resp_valid(bus_resp_valid), .bus_resp_rdata(bus_resp_rdata),
        .bus_resp_err(bus_resp_err)
    );

    always #5 clk = ~clk;

    // Observations recorded by the access driver (cycle k = k-th negedge after accept)
    bit          o_got, o_bus_seen, o_stable;
    int          o_cyc, o_pulse, o_bus_cycles;
    logic [63:0] o_rdata, o_baddr, o_bwdata;
    logic        o_err, o_bwr, o_ready_after, o_ready_start;
    logic [7:0]  o_bmask;

    function automatic logic [63:0] ref_load(logic [2:0] memop, logic [2:0] off, logic [63:0] data);
        int unsigned bytes;
        logic [63:0] r, keep;
        bytes = 1 << memop[1:0];
        r = data >> (8 * off);
        if (bytes == 8) return r;
        keep = (64'd1 << (8 * bytes)) - 64'd1;
        r = r & keep;
        if (!memop[2] && r[8 * bytes - 1]) r = r | ~keep;
        return r;
    endfunction

    function automatic logic [7:0] ref_mask(logic [2:0] memop, logic [2:0] off);
        logic [15:0] m;
        m = ((16'd1 << (1 << memop[1:0])) - 16'd1) << off;
        return m[7:0];
    endfunction

    function automatic bit ref_early_err(logic [2:0] memop, logic [63:0] addr);
        int unsigned bytes;
        bytes = 1 << memop[1:0];
        return (memop == 3'b111) || ((addr % bytes) != 0);
    endfunction

    // Drives one request and plays the bus side; records what the DUT did.
    task automatic run_access(input logic wr, input logic [63:0] addr, input logic [2:0] memop,
                              input logic [63:0] wdata, input int rdy_delay, input int resp_delay,
                              input logic [63:0] rdata, input logic berr);
        int  rq_cnt, resp_at;
        bit  hs_done;
        o_got = 0; o_bus_seen = 0; o_stable = 1; o_cyc = -1; o_pulse = 0; o_bus_cycles = 0;
        o_rdata = 'x; o_err = 1'bx; o_ready_after = 1'b0;
        rq_cnt = 0; resp_at = -1; hs_done = 0;
        @(negedge clk);
        o_ready_start = req_ready;
        req_valid = 1'b1; req_wr = wr; req_addr = addr; req_memop = memop; req_wdata = wdata;
        bus_resp_rdata = rdata; bus_resp_err = berr;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            req_valid = 1'b0;
            req_addr = {$urandom, $urandom};
            req_wdata = {$urandom, $urandom};
            if (resp_valid) begin
                if (!o_got) begin
                    o_got = 1; o_cyc = k; o_rdata = resp_rdata; o_err = resp_err;
                end
                o_pulse++;
            end else if (o_got) begin
                o_ready_after = req_ready;
                break;
            end
            if (bus_req_valid) begin
                if (!o_bus_seen) begin
                    o_bus_seen = 1; o_bwr = bus_req_wr; o_baddr = bus_req_addr;
                    o_bmask = bus_req_wmask; o_bwdata = bus_req_wdata;
                end else if (bus_req_wr !== o_bwr || bus_req_addr !== o_baddr ||
                             bus_req_wmask !== o_bmask || bus_req_wdata !== o_bwdata) begin
                    o_stable = 0;
                end
                rq_cnt++;
            end
            o_bus_cycles = rq_cnt;
            bus_req_ready = bus_req_valid && !hs_done && (rq_cnt > rdy_delay);
            if (bus_req_ready) begin
                hs_done = 1;
                if (resp_delay >= 0) resp_at = k + 1 + resp_delay;
            end
            bus_resp_valid = (k == resp_at);
        end
        bus_req_ready = 1'b0;
        bus_resp_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 0; req_wr = 0; req_addr = '0; req_memop = '0; req_wdata = '0;
        bus_req_ready = 0; bus_resp_valid = 0; bus_resp_rdata = '0; bus_resp_err = 0;
        repeat (3) @(negedge clk);
        n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", req_ready); end
        n_tests++; if ({resp_valid, resp_err, bus_req_valid, bus_req_wr} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_flags: got %b want 0000", {resp_valid, resp_err, bus_req_valid, bus_req_wr}); end
        n_tests++; if ({resp_rdata, bus_req_addr, bus_req_wdata, bus_req_wmask} !== '0) begin
            n_fail++; $display("FAIL reset_data: got %h/%h/%h/%h want 0", resp_rdata, bus_req_addr, bus_req_wdata, bus_req_wmask); end
        rst = 1'b0;
    endtask

    task automatic test_load_byte();
        run_access(1'b0, 64'h8000_0005, 3'b000, '0, 0, 0, 64'h0000_80FF_0000_0000, 1'b0);
        n_tests++; if (o_rdata !== 64'hFFFF_FFFF_FFFF_FF80) begin n_fail++; $display("FAIL lb_rdata: got %h want ffffffffffffff80", o_rdata); end
        n_tests++; if (o_err !== 1'b0) begin n_fail++; $display("FAIL lb_err: got %b want 0", o_err); end
        n_tests++; if (o_cyc !== 3) begin n_fail++; $display("FAIL lb_latency: got %0d want 3", o_cyc); end
        n_tests++; if (o_baddr !== 64'h8000_0000 || o_bmask !== 8'h00 || o_bwr !== 1'b0) begin
            n_fail++; $display("FAIL lb_bus: got addr %h mask %h wr %b want 80000000/00/0", o_baddr, o_bmask, o_bwr); end
    endtask

    task automatic test_store_half();
        logic [63:0] w;
        run_access(1'b1, 64'h8000_0006, 3'b001, 64'h1234, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        w = o_bwdata;
        n_tests++; if (o_baddr !== 64'h8000_0000) begin n_fail++; $display("FAIL sh_addr: got %h want 80000000", o_baddr); end
        n_tests++; if (o_bmask !== 8'hC0) begin n_fail++; $display("FAIL sh_mask: got %h want c0", o_bmask); end
        n_tests++; if (w[63:48] !== 16'h1234) begin n_fail++; $display("FAIL sh_wdata: got %h want 1234", w[63:48]); end
        n_tests++; if (o_rdata !== 64'd0 || o_err !== 1'b0) begin n_fail++; $display("FAIL sh_resp: got %h err %b want 0/0", o_rdata, o_err); end
    endtask

    task automatic test_misaligned();
        run_access(1'b0, 64'h8000_0002, 3'b010, '0, 0, 0, 64'h1111_2222_3333_4444, 1'b0);
        n_tests++; if (o_err !== 1'b1 || o_rdata !== 64'd0) begin n_fail++; $display("FAIL lw_mis_err: got err %b rdata %h want 1/0", o_err, o_rdata); end
        n_tests++; if (o_cyc !== 1) begin n_fail++; $display("FAIL lw_mis_latency: got %0d want 1", o_cyc); end
        n_tests++; if (o_bus_seen) begin n_fail++; $display("FAIL lw_mis_nobus: got bus_req_valid 1 want 0"); end
    endtask

    task automatic test_ready_stall();
        run_access(1'b0, 64'h4, 3'b110, '0, 5, 0, 64'hDEAD_BEEF_0BAD_F00D, 1'b0);
        n_tests++; if (o_bus_cycles !== 6 || !o_stable) begin n_fail++; $display("FAIL stall_req: got %0d cycles stable %0d want 6/1", o_bus_cycles, o_stable); end
        n_tests++; if (o_rdata !== 64'h0000_0000_DEAD_BEEF) begin n_fail++; $display("FAIL stall_lwu: got %h want 00000000deadbeef", o_rdata); end
        n_tests++; if (o_cyc !== 8) begin n_fail++; $display("FAIL stall_latency: got %0d want 8", o_cyc); end
    endtask

    task automatic test_timeout();
        run_access(1'b0, 64'h8000_0010, 3'b011, '0, 0, -1, '0, 1'b0);
        // S_WAIT entered at cycle 2; response expected TMO cycles later
        n_tests++; if (o_cyc !== 2 + TMO) begin n_fail++; $display("FAIL tmo_latency: got %0d want %0d", o_cyc, 2 + TMO); end
        n_tests++; if (o_err !== 1'b1 || o_rdata !== 64'd0) begin n_fail++; $display("FAIL tmo_err: got err %b rdata %h want 1/0", o_err, o_rdata); end
        n_tests++; if (o_ready_after !== 1'b1 || o_pulse !== 1) begin n_fail++; $display("FAIL tmo_ready: got ready %b pulse %0d want 1/1", o_ready_after, o_pulse); end
    endtask

    task automatic test_reset_mid();
        bit bad;
        @(negedge clk);
        req_valid = 1; req_wr = 0; req_addr = 64'h20; req_memop = 3'b011; req_wdata = '0;
        bus_resp_rdata = 64'hAAAA_5555_AAAA_5555; bus_resp_err = 0;
        @(negedge clk); req_valid = 0; bus_req_ready = 1;
        @(negedge clk); bus_req_ready = 0;
        @(negedge clk); rst = 1;
        #1;
        n_tests++; if (req_ready !== 1'b1 || bus_req_valid !== 1'b0 || resp_valid !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_async: got ready %b breq %b resp %b want 1/0/0", req_ready, bus_req_valid, resp_valid); end
        @(negedge clk); rst = 0; bus_resp_valid = 1;
        @(negedge clk); bus_resp_valid = 0;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            if (resp_valid !== 1'b0 || req_ready !== 1'b1) bad = 1;
            @(negedge clk);
        end
        n_tests++; if (bad) begin n_fail++; $display("FAIL rstmid_late_resp: got response/busy %b want 0", bad); end
        n_tests++; if ({resp_rdata, resp_err, bus_req_addr, bus_req_wdata, bus_req_wmask, bus_req_wr} !== '0) begin
            n_fail++; $display("FAIL rstmid_outputs: got %h %b %h want 0", resp_rdata, resp_err, bus_req_addr); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            logic        wr, berr, exp_err;
            logic [2:0]  memop, off;
            logic [63:0] addr, wdata, rdata, exp_rdata;
            int          rdy, d, exp_cyc;
            bit          early;
            wr = 1'($urandom);
            memop = 3'($urandom_range(0, 7));
            off = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) != 0) off = off & ~3'((1 << memop[1:0]) - 1);
            addr = {$urandom, $urandom_range(0, 32'hFFFF_FFF8) & 32'hFFFF_FFF8} | {61'd0, off};
            wdata = {$urandom, $urandom};
            rdata = {$urandom, $urandom};
            berr = ($urandom_range(0, 7) == 0);
            rdy = $urandom_range(0, 3);
            case ($urandom_range(0, 9))
                0: d = -1;
                1: d = 8;
                2: d = 7;
                default: d = $urandom_range(0, 3);
            endcase
            early = ref_early_err(memop, addr);
            if (early) begin exp_err = 1; exp_cyc = 1; end
            else if (d >= 0 && d < TMO) begin exp_err = berr; exp_cyc = 3 + rdy + d; end
            else begin exp_err = 1; exp_cyc = 2 + rdy + TMO; end
            exp_rdata = (exp_err || wr) ? 64'd0 : ref_load(memop, off, rdata);
            run_access(wr, addr, memop, wdata, rdy, d, rdata, berr);
            n_tests++; if (o_ready_start !== 1'b1) begin n_fail++; $display("FAIL rnd%0d_ready_in: got %b want 1", n, o_ready_start); end
            n_tests++; if (o_cyc !== exp_cyc) begin n_fail++; $display("FAIL rnd%0d_latency: got %0d want %0d", n, o_cyc, exp_cyc); end
            n_tests++; if (o_err !== exp_err) begin n_fail++; $display("FAIL rnd%0d_err: got %b want %b", n, o_err, exp_err); end
            n_tests++; if (o_rdata !== exp_rdata) begin n_fail++; $display("FAIL rnd%0d_rdata: got %h want %h", n, o_rdata, exp_rdata); end
            n_tests++; if (o_pulse !== 1 || o_ready_after !== 1'b1) begin n_fail++; $display("FAIL rnd%0d_pulse: got %0d ready %b want 1/1", n, o_pulse, o_ready_after); end
            n_tests++; if (o_bus_seen !== !early) begin n_fail++; $display("FAIL rnd%0d_bus_seen: got %0d want %0d", n, o_bus_seen, !early); end
            if (!early) begin
                n_tests++; if (o_baddr !== (addr & ~64'd7) || o_bwr !== wr) begin
                    n_fail++; $display("FAIL rnd%0d_bus_addr: got %h wr %b want %h wr %b", n, o_baddr, o_bwr, addr & ~64'd7, wr); end
                n_tests++; if (o_bmask !== (wr ? ref_mask(memop, off) : 8'h00)) begin
                    n_fail++; $display("FAIL rnd%0d_mask: got %h want %h", n, o_bmask, wr ? ref_mask(memop, off) : 8'h00); end
                n_tests++; if (!o_stable || o_bus_cycles !== rdy + 1) begin
                    n_fail++; $display("FAIL rnd%0d_req_hold: got stable %0d cycles %0d want 1/%0d", n, o_stable, o_bus_cycles, rdy + 1); end
                if (wr) begin
                    n_tests++; if (o_bwdata !== (wdata << (8 * off))) begin
                        n_fail++; $display("FAIL rnd%0d_wdata: got %h want %h", n, o_bwdata, wdata << (8 * off)); end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_byte();
        test_store_half();
        test_misaligned();
        test_ready_stall();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
